// File: rtl/reaction_auto_player.sv
// ============================================================================
// Module   : reaction_auto_player
// Purpose  : Automated player for the reaction-timer game. Waits for a one-hot
//            target LED and then, after a programmable number of milliseconds,
//            raises the matching switch bit so the timer controller stops.
// Revision : 1.0 - initial release
//
// Ports:
//   clk        system clock (25 MHz nominal)
//   rst_n      asynchronous active-low reset
//   set        1 = setup/restart round, 0 = counting
//   enable     auto-player active
//   led        target LED vector from the timer controller
//   delay_ms   response latency in ms, sampled when the target is captured
//   sw         emulated switches (always zero or one-hot)
//   busy       high while the delay countdown runs
//   pressed    one-cycle pulse when a switch is raised
//   target_err sticky flag: a multi-hot LED vector was seen while armed
//
// Optional feature (macro AUTO_PLAYER_JITTER_EN):
//   When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) adds
//   0..15 ms of jitter to the captured delay.
// ============================================================================
`default_nettype none

module reaction_auto_player #(
  parameter int CLK_PER_MS = 25000,
  parameter int DLY_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             enable,
  input  logic [7:0]       led,
  input  logic [DLY_W-1:0] delay_ms,
  output logic [7:0]       sw,
  output logic             busy,
  output logic             pressed,
  output logic             target_err
);

  localparam int PS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    DELAY = 3'd2,
    PRESS = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state;
  logic [PS_W-1:0]  prescaler;
  logic [DLY_W:0]   remaining;   // one extra bit so delay + jitter cannot overflow
  logic [2:0]       idx;

  logic             led_one;
  logic             led_multi;
  logic [2:0]       led_pos;
  logic [DLY_W:0]   capture_val;

  // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
  assign led_one   = (led != 8'd0) && ((led & (led - 8'd1)) == 8'd0);
  assign led_multi = (led != 8'd0) && !led_one;

  always_comb begin
    led_pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (led[i]) led_pos = 3'(i);
    end
  end

`ifdef AUTO_PLAYER_JITTER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign capture_val = {1'b0, delay_ms} + (DLY_W+1)'(lfsr[3:0]);
`else
  assign capture_val = {1'b0, delay_ms};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prescaler  <= '0;
      remaining  <= '0;
      idx        <= 3'd0;
      sw         <= 8'd0;
      busy       <= 1'b0;
      pressed    <= 1'b0;
      target_err <= 1'b0;
    end else begin
      // A restart request always clears the sticky error, whatever the state.
      if (set) target_err <= 1'b0;

      if (set || !enable) begin
        // Abort has priority over every other transition.
        state   <= IDLE;
        sw      <= 8'd0;
        busy    <= 1'b0;
        pressed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sw      <= 8'd0;
            busy    <= 1'b0;
            pressed <= 1'b0;
            state   <= ARM;
          end
          ARM: begin
            if (led_one) begin
              idx       <= led_pos;
              remaining <= capture_val;
              prescaler <= '0;
              busy      <= 1'b1;
              state     <= DELAY;
            end else if (led_multi) begin
              target_err <= 1'b1;
            end
          end
          DELAY: begin
            // The target was latched at capture; led is ignored here.
            if (remaining == '0) begin
              state <= PRESS;
            end else if (prescaler == PS_LAST) begin
              prescaler <= '0;
              remaining <= remaining - (DLY_W+1)'(1);
            end else begin
              prescaler <= prescaler + PS_W'(1);
            end
          end
          PRESS: begin
            sw      <= 8'd1 << idx;
            pressed <= 1'b1;
            busy    <= 1'b0;
            state   <= HOLD;
          end
          HOLD: begin
            pressed <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reaction_auto_player.sv
// ============================================================================
// Module   : tb_reaction_auto_player
// Purpose  : Self-checking bench for reaction_auto_player (CLK_PER_MS = 4).
//            A cycle-count model predicts every output from the capture time
//            and latency; directed steps add literal expectations, then a
//            randomized phase exercises aborts, multi-hot targets and delays.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reaction_auto_player;

  localparam int C     = 4;
  localparam int DLY_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             set = 1'b1;
  logic             enable = 1'b1;
  logic [7:0]       led = 8'd0;
  logic [DLY_W-1:0] delay_ms = '0;
  logic [7:0]       sw;
  logic             busy;
  logic             pressed;
  logic             target_err;

  int checks = 0;
  int failures = 0;

  reaction_auto_player #(.CLK_PER_MS(C), .DLY_W(DLY_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set        (set),
    .enable     (enable),
    .led        (led),
    .delay_ms   (delay_ms),
    .sw         (sw),
    .busy       (busy),
    .pressed    (pressed),
    .target_err (target_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model -----------------
  // The player is either inactive, armed (waiting for a target), or has
  // captured a target at cycle t_cap with latency lat (ms). Outputs follow
  // directly from the number of cycles elapsed since the capture.
  int         cyc = 0;
  bit         m_active = 0;
  bit         m_captured = 0;
  bit         m_err = 0;
  int         t_cap = 0;
  int         lat = 0;
  logic [7:0] tgt = 8'd0;
  logic [7:0] lf = 8'hA5;

  function automatic int jitter(input logic [7:0] v);
`ifdef AUTO_PLAYER_JITTER_EN
    return int'(v[3:0]);
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   <= 0;
      m_captured <= 0;
      m_err      <= 0;
      lf         <= 8'hA5;
    end else begin
      cyc <= cyc + 1;
      lf  <= {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      if (set || !enable) begin
        m_active   <= 0;
        m_captured <= 0;
        if (set) m_err <= 0;
      end else if (!m_active) begin
        m_active <= 1;
      end else if (!m_captured) begin
        if ($countones(led) == 1) begin
          m_captured <= 1;
          t_cap      <= cyc + 1;
          lat        <= int'(delay_ms) + jitter(lf);
          tgt        <= led;
        end else if ($countones(led) > 1) begin
          m_err <= 1;
        end
      end
    end
  end

  // Single compare process: every falling edge, outputs vs. model.
  always @(negedge clk) begin
    logic [7:0] e_sw;
    logic       e_busy;
    logic       e_pr;
    int         d;
    int         p;
    e_sw = 8'd0; e_busy = 1'b0; e_pr = 1'b0;
    if (rst_n && m_captured) begin
      d = cyc - t_cap;
      p = 2 + lat * C;
      e_sw   = (d >= p) ? tgt : 8'd0;
      e_busy = (d < p);
      e_pr   = (d == p);
    end
    chk("model_sw", 32'(sw), 32'(e_sw));
    chk("model_busy", 32'(busy), 32'(e_busy));
    chk("model_pressed", 32'(pressed), 32'(e_pr));
    chk("model_err", 32'(target_err), 32'(rst_n ? m_err : 1'b0));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus -----------------
  initial begin
    // 1. reset, then setup mode
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rst_sw", 32'(sw), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pressed", 32'(pressed), 32'h0);
    chk("rst_err", 32'(target_err), 32'h0);
    set = 1'b0;
    tick(1);
    chk("arm_sw", 32'(sw), 32'h0);

    // 2. delay 3 ms: press at edge N+14
    delay_ms = 10'd3;
    led = 8'b0010_0000;
    tick(1);                                   // after edge N
    chk("t2_busy_N", 32'(busy), 32'h1);
    tick(13);                                  // after N+13
    chk("t2_sw_N13", 32'(sw), 32'h0);
    chk("t2_busy_N13", 32'(busy), 32'h1);
    tick(1);                                   // after N+14
    chk("t2_sw_N14", 32'(sw), 32'h20);
    chk("t2_pressed_N14", 32'(pressed), 32'h1);
    chk("t2_busy_N14", 32'(busy), 32'h0);
    tick(1);
    chk("t2_pressed_N15", 32'(pressed), 32'h0);
    chk("t2_sw_hold", 32'(sw), 32'h20);
    set = 1'b1; led = 8'd0;
    tick(1);
    chk("t2_sw_clear", 32'(sw), 32'h0);
    set = 1'b0;
    tick(1);

    // 3. delay 0: sw[0] at N+2, later led changes ignored
    delay_ms = 10'd0;
    led = 8'b0000_0001;
    tick(2);
    chk("t3_sw_N1", 32'(sw), 32'h0);
    tick(1);
    chk("t3_sw_N2", 32'(sw), 32'h1);
    led = 8'b1000_0000;
    tick(3);
    chk("t3_sw_kept", 32'(sw), 32'h1);
    set = 1'b1; led = 8'd0;
    tick(1);
    set = 1'b0;
    tick(1);

    // 4. multi-hot target, then a valid one with delay 1
    led = 8'b0001_1000;
    tick(2);
    chk("t4_err", 32'(target_err), 32'h1);
    chk("t4_sw", 32'(sw), 32'h0);
    delay_ms = 10'd1;
    led = 8'b0000_0100;
    tick(6);                                   // after N+5
    chk("t4_sw_N5", 32'(sw), 32'h0);
    tick(1);                                   // after N+6
    chk("t4_sw_N6", 32'(sw), 32'h4);
    chk("t4_err_kept", 32'(target_err), 32'h1);
    set = 1'b1; led = 8'd0;
    tick(1);
    chk("t4_err_clear", 32'(target_err), 32'h0);
    set = 1'b0;
    tick(1);

    // 5. disable midway through a 5 ms delay
    delay_ms = 10'd5;
    led = 8'b0000_0010;
    tick(10);
    chk("t5_busy_mid", 32'(busy), 32'h1);
    enable = 1'b0;
    tick(1);
    chk("t5_busy_abort", 32'(busy), 32'h0);
    led = 8'd0;
    tick(30);
    chk("t5_sw_never", 32'(sw), 32'h0);
    enable = 1'b1;
    tick(1);
    delay_ms = 10'd0;
    led = 8'b0100_0000;
    tick(3);
    chk("t5_recapture", 32'(sw), 32'h40);

    // 6. asynchronous reset during HOLD
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_sw", 32'(sw), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      set    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       led = 8'd0;
          1, 2:    led = 8'd1 << $urandom_range(0, 7);
          default: led = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) delay_ms = DLY_W'($urandom_range(0, 3));
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
